// File: rtl/mc8051_pkg.sv
// Shared MCS-51 peripheral definitions: SFR addresses, SCON bit positions and
// the UART state encoding used by both the transmitter and receiver.
package mc8051_pkg;

    localparam logic [7:0] SFR_SCON = 8'h98;
    localparam logic [7:0] SFR_SBUF = 8'h99;

    localparam int SCON_RI  = 0;
    localparam int SCON_TI  = 1;
    localparam int SCON_RB8 = 2;
    localparam int SCON_TB8 = 3;
    localparam int SCON_REN = 4;
    localparam int SCON_SM2 = 5;
    localparam int SCON_SM1 = 6;
    localparam int SCON_SM0 = 7;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/mc8051_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done on the last cycle of each period.
module mc8051_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_done = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= bit_done ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/mc8051_uart_tx.sv
// MCS-51 serial transmitter, Mode 1 (start, 8 data LSB-first, stop).
// Owns SCON and the write side of SBUF on the SFR bus.
module mc8051_uart_tx
    import mc8051_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SCON_ADDR    = SFR_SCON,
    parameter logic [7:0] SBUF_ADDR    = SFR_SBUF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] sfr_addr,
    input  logic       sfr_wr,
    input  logic [7:0] sfr_wdata,
    input  logic       sfr_rd,
    output logic [7:0] sfr_rdata,
    output logic       sfr_rd_hit,
    output logic       txd,
    output logic       ti_irq,
    output logic       tx_busy
);

    uart_state_e state;
    logic [7:0]  shift;
    logic [7:0]  scon;
    logic [2:0]  bit_idx;
    logic        bit_done;
    logic        ti_set;
    logic        sbuf_wr;
    logic        scon_wr;
    logic        stop_enter;

    assign sbuf_wr    = sfr_wr && (sfr_addr == SBUF_ADDR);
    assign scon_wr    = sfr_wr && (sfr_addr == SCON_ADDR);
    assign stop_enter = (state == UART_DATA) && bit_done && (bit_idx == 3'd7);

    assign sfr_rdata  = (sfr_addr == SCON_ADDR) ? scon : 8'h00;
    assign sfr_rd_hit = sfr_rd && (sfr_addr == SCON_ADDR);
    assign ti_irq     = scon[SCON_TI];

    mc8051_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (state == UART_IDLE),
        .enable   (state != UART_IDLE),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= UART_IDLE;
            shift   <= 8'h00;
            bit_idx <= 3'd0;
        end else begin
            case (state)
                UART_IDLE: if (sbuf_wr) begin
                    shift   <= sfr_wdata;
                    bit_idx <= 3'd0;
                    state   <= UART_START;
                end
                UART_START: if (bit_done) state <= UART_DATA;
                UART_DATA: if (bit_done) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= UART_STOP;
                end
                UART_STOP: if (bit_done) state <= UART_IDLE;
                default: state <= UART_IDLE;
            endcase
        end
    end

    // Line and busy are registered, so everything visible lags the FSM by one
    // cycle; ti_set is delayed the same way so TI lines up with the stop bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            ti_set  <= 1'b0;
        end else begin
            tx_busy <= (state != UART_IDLE);
            ti_set  <= stop_enter;
            case (state)
                UART_START: txd <= 1'b0;
                UART_DATA:  txd <= shift[0];
                default:    txd <= 1'b1;
            endcase
        end
    end

    // Hardware TI set overrides a simultaneous software write of bit 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scon <= 8'h00;
        end else begin
            if (scon_wr) scon <= sfr_wdata;
            if (ti_set)  scon[SCON_TI] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc8051_uart_tx.sv
// Directed + randomized bench for mc8051_uart_tx with CLKS_PER_BIT=4; expected
// line levels come from a frame-bit array indexed by elapsed cycle.
module tb_mc8051_uart_tx;

    localparam int         CPB  = 4;
    localparam logic [7:0] SCON = 8'h98;
    localparam logic [7:0] SBUF = 8'h99;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] sfr_addr;
    logic       sfr_wr;
    logic [7:0] sfr_wdata;
    logic       sfr_rd;
    logic [7:0] sfr_rdata;
    logic       sfr_rd_hit;
    logic       txd;
    logic       ti_irq;
    logic       tx_busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] scon_m;

    always #5 clk = ~clk;

    mc8051_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .SCON_ADDR    (SCON),
        .SBUF_ADDR    (SBUF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sfr_addr   (sfr_addr),
        .sfr_wr     (sfr_wr),
        .sfr_wdata  (sfr_wdata),
        .sfr_rd     (sfr_rd),
        .sfr_rdata  (sfr_rdata),
        .sfr_rd_hit (sfr_rd_hit),
        .txd        (txd),
        .ti_irq     (ti_irq),
        .tx_busy    (tx_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_scon(input string tag, input logic [7:0] exp);
        sfr_addr = SCON;
        sfr_rd   = 1'b1;
        #1;
        chk({tag, "_rdata"}, {24'd0, sfr_rdata}, {24'd0, exp});
        chk({tag, "_hit"}, {31'd0, sfr_rd_hit}, 32'd1);
        sfr_rd = 1'b0;
    endtask

    task automatic write_sfr(input logic [7:0] a, input logic [7:0] d);
        sfr_addr  = a;
        sfr_wdata = d;
        sfr_wr    = 1'b1;
        @(posedge clk); #1;
        sfr_wr = 1'b0;
        if (a == SCON) scon_m = d;
    endtask

    // Sends byte d (accepted at edge N) and checks 44 cycles after it. An
    // optional side write is presented so that it is sampled at edge N+side_k.
    task automatic run_frame(input logic [7:0] d, input int side_k,
                             input logic [7:0] side_a, input logic [7:0] side_d);
        logic [9:0] fr;
        logic       exp_txd;
        fr = {1'b1, d, 1'b0};
        write_sfr(SBUF, d);
        chk("txd_at_n", {31'd0, txd}, 32'd1);
        for (int k = 1; k <= 44; k++) begin
            if (k == side_k) begin
                sfr_addr  = side_a;
                sfr_wdata = side_d;
                sfr_wr    = 1'b1;
            end
            @(posedge clk); #1;
            sfr_wr = 1'b0;
            if (k == side_k && side_a == SCON) scon_m = side_d;
            if (k == 9 * CPB + 1) scon_m[1] = 1'b1;
            exp_txd = (k <= 10 * CPB) ? fr[(k - 1) / CPB] : 1'b1;
            chk($sformatf("txd_k%0d_d%02h", k, d), {31'd0, txd}, {31'd0, exp_txd});
            chk($sformatf("busy_k%0d", k), {31'd0, tx_busy}, {31'd0, (k <= 10 * CPB)});
            chk($sformatf("ti_k%0d", k), {31'd0, ti_irq}, {31'd0, scon_m[1]});
        end
    endtask

    initial begin
        logic [7:0] d;
        reset_n   = 1'b0;
        sfr_addr  = 8'h00;
        sfr_wr    = 1'b0;
        sfr_wdata = 8'h00;
        sfr_rd    = 1'b0;
        scon_m    = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_ti", {31'd0, ti_irq}, 32'd0);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        read_scon("rst_scon", 8'h00);

        // 0xA5 with an ignored SBUF write mid-frame; no second frame follows
        run_frame(8'hA5, 10, SBUF, 8'h3C);
        read_scon("a5_scon", 8'h02);

        // SCON write collides with hardware TI set
        write_sfr(SCON, 8'h00);
        chk("ti_clr1", {31'd0, ti_irq}, 32'd0);
        run_frame(8'($urandom), 9 * CPB + 1, SCON, 8'h00);
        read_scon("collide_scon", 8'h02);
        chk("collide_ti", {31'd0, ti_irq}, 32'd1);
        write_sfr(SCON, 8'h00);
        chk("ti_clr2", {31'd0, ti_irq}, 32'd0);
        read_scon("clr_scon", 8'h00);

        // Randomized frames, TI left set between them
        for (int i = 0; i < 4; i++) run_frame(8'($urandom), 0, 8'h00, 8'h00);

        // Asynchronous reset mid-frame
        d = 8'($urandom) & 8'hFE;
        write_sfr(SBUF, d);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, tx_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_txd", {31'd0, txd}, 32'd1);
        chk("arst_busy", {31'd0, tx_busy}, 32'd0);
        chk("arst_ti", {31'd0, ti_irq}, 32'd0);
        scon_m = 8'h00;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_txd", {31'd0, txd}, 32'd1);
        run_frame(8'($urandom), 0, 8'h00, 8'h00);

        // SBUF reads are not claimed; SCON is fully R/W
        sfr_addr = SBUF;
        sfr_rd   = 1'b1;
        #1;
        chk("sbuf_rd_hit", {31'd0, sfr_rd_hit}, 32'd0);
        chk("sbuf_rdata", {24'd0, sfr_rdata}, 32'd0);
        sfr_rd = 1'b0;
        write_sfr(SCON, 8'hF5);
        read_scon("scon_f5", 8'hF5);
        chk("f5_ti", {31'd0, ti_irq}, 32'd0);
        write_sfr(SCON, 8'h5A);
        read_scon("scon_5a", scon_m);
        chk("5a_ti", {31'd0, ti_irq}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
